// File: rtl/fifo_pkg.sv
//==============================================================
// Package : fifo_pkg
// Desc    : Shared constants and index/count helpers for FIFO blocks
// Rev     : 1.0
//==============================================================
`default_nettype none

package fifo_pkg;

  localparam int MAX_PORTS = 8;

  // Wraps by conditional subtraction so depth need not be a power of two.
  // Assumes base < depth and offset <= depth.
  function automatic int unsigned mod_add(input int unsigned base,
                                          input int unsigned offset,
                                          input int unsigned depth);
    int unsigned sum;
    sum = base + offset;
    return (sum >= depth) ? (sum - depth) : sum;
  endfunction

  function automatic logic [3:0] popcount(input logic [MAX_PORTS-1:0] vec);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      cnt = cnt + {3'b000, vec[i]};
    end
    return cnt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/write_packer_if.sv
//==============================================================
// Interface : write_packer_if
// Desc      : Lane input beat and compacted write-port bus
// Rev       : 1.0
//==============================================================
`default_nettype none

interface write_packer_if #(
  parameter int WIDTH = 8,
  parameter int LANES = 4
);
  localparam int CW = $clog2(LANES + 1);

  logic [LANES-1:0]            in_valid;
  logic [LANES-1:0][WIDTH-1:0] in_data;
  logic                        in_ready;
  logic [LANES-1:0][WIDTH-1:0] out_data;
  logic [CW-1:0]               out_count;
  logic [CW-1:0]               out_take;

  modport master (
    output in_valid, in_data, out_take,
    input  in_ready, out_data, out_count
  );

  modport slave (
    input  in_valid, in_data, out_take,
    output in_ready, out_data, out_count
  );
endinterface

`default_nettype wire

// File: rtl/lane_compact.sv
//==============================================================
// Module : lane_compact
// Desc   : Removes gaps from a sparse lane beat via running prefix sum
// Rev    : 1.0
//==============================================================
`default_nettype none

module lane_compact
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LANES = 4
) (
  input  logic [LANES-1:0]               in_valid,
  input  logic [LANES-1:0][WIDTH-1:0]    in_data,
  output logic [LANES-1:0][WIDTH-1:0]    comp_data,
  output logic [$clog2(LANES+1)-1:0]     push_cnt
);
  localparam int CW = $clog2(LANES + 1);

  // Each valid lane lands in the slot given by the number of valid lanes below it.
  always_comb begin : comb_compact
    logic [CW-1:0] w_pos;
    comp_data = '0;
    w_pos     = '0;
    for (int i = 0; i < LANES; i++) begin
      if (in_valid[i]) begin
        for (int j = 0; j < LANES; j++) begin
          if (w_pos == CW'(j)) begin
            comp_data[j] = in_data[i];
          end
        end
      end
      w_pos = w_pos + CW'(in_valid[i]);
    end
    push_cnt = w_pos;
  end

endmodule

`default_nettype wire

// File: rtl/write_packer.sv
//==============================================================
// Module : write_packer
// Desc   : Packs sparse lane beats into a ring feeding FIFO write ports
// Rev    : 1.0
//==============================================================
`default_nettype none

module write_packer
  import fifo_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int LANES       = 4,
  parameter int STAGE_DEPTH = 2 * LANES
) (
  input  logic                               clk,
  input  logic                               srst,
  write_packer_if.slave                      bus,
  output logic [$clog2(STAGE_DEPTH+1)-1:0]   level,
  output logic                               take_err
);
  localparam int CW = $clog2(LANES + 1);
  localparam int IW = $clog2(STAGE_DEPTH);
  localparam int LW = $clog2(STAGE_DEPTH + 1);

  logic [WIDTH-1:0]            r_ring [STAGE_DEPTH];
  logic [IW-1:0]               r_head;
  logic [IW-1:0]               r_tail;
  logic [LW-1:0]               r_count;
  logic                        r_take_err;

  logic [LANES-1:0][WIDTH-1:0] w_comp_data;
  logic [CW-1:0]               w_push_cnt;
  logic [CW-1:0]               w_out_count;
  logic [CW-1:0]               w_take;
  logic                        w_ready;
  logic                        w_push;
  logic                        w_over;

  lane_compact #(
    .WIDTH (WIDTH),
    .LANES (LANES)
  ) u_lane_compact (
    .in_valid  (bus.in_valid),
    .in_data   (bus.in_data),
    .comp_data (w_comp_data),
    .push_cnt  (w_push_cnt)
  );

  // Readiness looks only at registered occupancy, so a same-cycle take never helps.
  assign w_ready     = !srst && (r_count <= LW'(STAGE_DEPTH - LANES));
  assign w_push      = w_ready && (|bus.in_valid);
  assign w_out_count = (r_count >= LW'(LANES)) ? CW'(LANES) : CW'(r_count);
  assign w_over      = bus.out_take > w_out_count;
  assign w_take      = w_over ? w_out_count : bus.out_take;

  always_comb begin
    bus.out_data = '0;
    for (int k = 0; k < LANES; k++) begin
      if (CW'(k) < w_out_count) begin
        bus.out_data[k] = r_ring[IW'(mod_add(32'(r_head), k, STAGE_DEPTH))];
      end
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.out_count = w_out_count;
  assign level         = r_count;
  assign take_err      = r_take_err;

  always_ff @(posedge clk) begin
    if (srst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_take_err <= 1'b0;
    end else begin
      r_head  <= IW'(mod_add(32'(r_head), 32'(w_take), STAGE_DEPTH));
      r_count <= r_count - LW'(w_take) + (w_push ? LW'(w_push_cnt) : '0);
      if (w_push) begin
        r_tail <= IW'(mod_add(32'(r_tail), 32'(w_push_cnt), STAGE_DEPTH));
      end
      if (w_over) begin
        r_take_err <= 1'b1;
      end
    end
  end

  // Storage is not reset; reset only rewinds the pointers.
  always_ff @(posedge clk) begin
    for (int k = 0; k < LANES; k++) begin
      if (w_push && (CW'(k) < w_push_cnt)) begin
        r_ring[IW'(mod_add(32'(r_tail), k, STAGE_DEPTH))] <= w_comp_data[k];
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/write_packer.md
WRITE_PACKER -- requirements
Module: write_packer

Interface
REQ-001 Parameter WIDTH, 8, data bits per lane.
REQ-002 Parameter LANES, 4, input lanes and output write ports; legal range 1..8.
REQ-003 Parameter STAGE_DEPTH, 2*LANES, entries in the internal staging ring; must be at least 2*LANES.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 srst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  LANES  per-lane valid; any bit pattern is legal, including sparse patterns.
REQ-007 in_data  input  LANES x WIDTH  per-lane payload.
REQ-008 in_ready  output  1  beat acceptance; all valid lanes are taken or none are.
REQ-009 out_data  output  LANES x WIDTH  compacted entries for the downstream multiport FIFO write ports.
REQ-010 out_count  output  clog2(LANES+1)  number of valid entries, contiguous from port 0.
REQ-011 out_take  input  clog2(LANES+1)  number of entries the downstream consumes this cycle, from port 0 upward.
REQ-012 level  output  clog2(STAGE_DEPTH+1)  current staging occupancy.
REQ-013 take_err  output  1  sticky flag: out_take exceeded out_count.

Function
REQ-014 The ring SHALL hold head, tail and count registers; indices wrap modulo STAGE_DEPTH; wrap SHALL NOT use power-of-two truncation.
REQ-015 in_ready SHALL be 1 when count <= STAGE_DEPTH-LANES and srst=0, otherwise 0, derived only from registered count.
REQ-016 A push occurs when in_ready=1 and in_valid is nonzero; push size p SHALL equal popcount(in_valid).
REQ-017 Pushed lanes SHALL be written to tail, tail+1, ... in ascending lane index with gaps removed, e.g. in_valid=1010 writes lane1 then lane3.
REQ-018 in_valid=0 with in_ready=1 SHALL leave state unchanged; when in_ready=0 the inputs SHALL be ignored entirely.
REQ-019 out_count SHALL equal min(count, LANES); out_data[k] SHALL equal ring[head+k mod STAGE_DEPTH] for k < out_count and 0 otherwise.
REQ-020 Effective take t SHALL equal min(out_take, out_count); head advances by t modulo STAGE_DEPTH.
REQ-021 When out_take > out_count, take_err SHALL be set to 1 on the next edge and held until srst.
REQ-022 A simultaneous push and take SHALL give count_next = count - t + p; in_ready SHALL NOT account for same-cycle frees.
REQ-023 Latency SHALL be one cycle from an accepted push to those entries appearing on out_data; out_* SHALL be combinational from registers only, with no path from out_take.
REQ-024 Order SHALL be global FIFO: beat order first, then lane order within each beat, with no loss or duplication.
REQ-025 level SHALL equal count.

Reset
REQ-026 srst=1 SHALL clear head, tail, count and take_err on the next edge; on that edge pushes and takes SHALL be discarded.
REQ-027 While srst=1, in_ready=0; after srst deasserts, in_ready=1, out_count=0, out_data all 0, level=0.
REQ-028 srst asserted mid-stream SHALL discard all staged data; ring contents need not be cleared.

Structure
REQ-029 Shared package fifo_pkg SHALL hold MAX_PORTS=8, a modular add function (base, offset, depth), and a popcount function.
REQ-030 Sub-module lane_compact SHALL be purely combinational, taking in_valid and in_data and producing the compacted lanes plus p via a prefix-sum.
REQ-031 The ring SHALL be a register array, because it has multiple write and read ports.

Verification (WIDTH=8, LANES=4, STAGE_DEPTH=8)
REQ-032 Test sparse compaction: push in_valid=1010 with lanes {A0,B1,C2,D3}; out_take=0 -> next cycle out_count=2, out_data[0]=B1, out_data[1]=D3, level=2.
REQ-033 Test backpressure: push 4 entries at take=0 until full -> after two beats level=8 and in_ready=0; a third beat is ignored and level stays 8.
REQ-034 Test wrap-around: 20 beats of random in_valid with random legal out_take -> output sequence equals scoreboard order; head wraps past index 7 at least twice.
REQ-035 Test simultaneous push and take at level=4: push 3, take 4 -> next cycle level=3 and out_data[0] is the first newly pushed entry.
REQ-036 Test illegal take: out_count=1, out_take=3 -> head advances 1, level=0, take_err=1 and held until srst.
REQ-037 Test reset mid-stream: level=6, srst pulse one cycle -> next cycle level=0, out_count=0, take_err=0, in_ready=1.
